spi_wishbone_bridge: RTL and testbench
======================================

# spi_wishbone_bridge

SPI-slave to Wishbone-master bridge; the stage upstream of the general-purpose register bank. Turns SPI frames from an external host (MCU, FTDI) into single Wishbone B4 read/write cycles on the `wb_*` bus that feeds the register bank. SPI inputs are asynchronous to `clk_i` and are oversampled. Address auto-increments within one chip-select frame.

## Interface
- `AddrSz`, 4: Wishbone address width; must be ≤ 7.
- `DataSz`, 8: Wishbone data width; fixed at 8, one SPI byte per bus cycle.

- `clk_i`  in  1  system clock; all logic in this domain.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `spi_sck_i`  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous.
- `spi_csn_i`  in  1  chip select, active-low, asynchronous.
- `spi_sdi_i`  in  1  MOSI, MSB first.
- `spi_sdo_o`  out  1  MISO, MSB first.
- `wb_we_o`  out  1  write enable.
- `wb_stb_o`  out  1  strobe; held until `wb_ack_i`.
- `wb_ack_i`  in  1  acknowledge; may be combinational from `wb_stb_o`.
- `wb_adr_o`  out  AddrSz  address.
- `wb_dat_o`  out  DataSz  write data.
- `wb_dat_i`  in  DataSz  read data; sampled when `wb_ack_i`=1.

## Operation
- Synchronisation: `spi_sck_i`, `spi_csn_i` and `spi_sdi_i` each pass through a 2-flop synchroniser. A third flop on SCK detects rise/fall edges. SDI is sampled on the detected SCK rise.
- Frame: CSN low, then a command byte, then N ≥ 0 data bytes, then CSN high.
- Command byte: bit7 = `we`. Bits[AddrSz-1:0] = start address. The remaining bits are ignored.
- States: IDLE, CMD, WB, DATA.
  - IDLE -> CMD on synchronised CSN low. The bit counter clears.
  - CMD: shifts 8 bits. On the 8th rise, latch `we` and the address.
    - Read: -> WB with `wb_we_o`=0.
    - Write: -> DATA.
  - DATA: shifts 8 bits. On the 8th rise:
    - Write: present the byte on `wb_dat_o` and go -> WB with `wb_we_o`=1.
    - Read: increment the address and go -> WB for the prefetch of the next byte.
  - WB: `wb_stb_o`=1 until `wb_ack_i`. In the ack cycle:
    - Read: load `wb_dat_i` into the TX shift register.
    - Write: increment the address.
    - Then -> DATA, or -> IDLE if CSN is high.
- Address arithmetic: modulo 2^AddrSz. 0xF+1 -> 0x0 for AddrSz=4.
- MISO: `spi_sdo_o` = TX[7]. TX shifts left on each detected SCK fall while in DATA. Shifts in 0. `spi_sdo_o`=0 in CMD and in IDLE.
- CSN high mid-byte: discard the partial byte and issue no bus cycle. -> IDLE.
- CSN high during WB: finish the cycle (wait for ack), then -> IDLE. Never drop `wb_stb_o` before ack.
- Read frames always fetch one byte beyond the last byte clocked out. The register bank has no read side effects, so this is acceptable.
- Reset, asynchronous at any time:
  - State = IDLE.
  - All outputs 0: `wb_stb_o`, `wb_we_o`, `wb_adr_o`, `wb_dat_o`, `spi_sdo_o`.
  - Synchronisers, shift registers and counters are cleared.
  - An in-flight bus cycle is abandoned.

## Timing
- Edge detection latency: 3 `clk_i` cycles from a pin edge to the internal event.
- SCK high time and low time: ≥ 4 `clk_i` each.
- CSN fall to first SCK rise: ≥ 4 `clk_i`.
- Last SCK fall to CSN rise: ≥ 4 `clk_i`.
- `wb_stb_o` rises 1 cycle after the internal 8th-rise event.
- With a combinational ack, `wb_stb_o` is high for exactly 1 cycle.
- Write data and address are stable the whole time `wb_stb_o`=1.
- Read turnaround: the host leaves ≥ 8 `clk_i` between the last SCK rise of a byte and the next SCK rise. This holds for the command byte and for each read data byte. It is required when ack latency ≤ 2 cycles. Add ack latency on top.
- After the ack, `spi_sdo_o` shows the new MSB on the next cycle.
- Bus throughput: at most one Wishbone cycle per SPI byte. No back-to-back strobes without a new byte.

## Test plan
- Write: frame 0x82, 0x5A with AddrSz=4.
  - One strobe: `wb_we_o`=1, `wb_adr_o`=2, `wb_dat_o`=0x5A.
  - Register-bank model reg2 = 0x5A.
- Burst write: 0x8E, 0x11, 0x22, 0x33.
  - Writes go to addresses 0xE, 0xF, 0x0 (wrap).
  - Exactly 3 strobes.
- Read: preload reg1 = 0xA5. Send frame 0x01, 0x00.
  - MISO returns 0xA5 in byte 1.
  - 2 read strobes, at adr 1 then adr 2 (prefetch).
  - `spi_sdo_o`=0 during the command byte.
- Abort: CSN high after 5 bits of a write data byte.
  - No write strobe.
  - The next frame 0x83, 0x77 writes 0x77 to adr 3 correctly.
- Slow ack: the slave delays ack by 3 cycles.
  - `wb_stb_o` held 4 cycles; address and data stable.
  - CSN raised during the wait: the cycle still completes.
- Reset: assert `rst_i` mid-burst with no `clk_i` edge.
  - All outputs 0 immediately.
  - After release, a new frame works from IDLE.

Source files
------------

// File: rtl/spi_wishbone_bridge.sv
// rtl/spi_wishbone_bridge.sv - SPI mode-0 slave to Wishbone B4 single-cycle master bridge
// Frame: command byte (bit7 = we, low bits = start address), then data bytes with address auto-increment.
module spi_wishbone_bridge #(
  parameter int AddrSz = 4,
  parameter int DataSz = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spi_sck_i,
  input  logic              spi_csn_i,
  input  logic              spi_sdi_i,
  output logic              spi_sdo_o,
  output logic              wb_we_o,
  output logic              wb_stb_o,
  input  logic              wb_ack_i,
  output logic [AddrSz-1:0] wb_adr_o,
  output logic [DataSz-1:0] wb_dat_o,
  input  logic [DataSz-1:0] wb_dat_i
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WB,
    DATA
  } state_t;

  state_t              state;
  logic [2:0]          sck_q;
  logic [1:0]          csn_q;
  logic [1:0]          sdi_q;
  logic [2:0]          bit_cnt;
  logic [DataSz-2:0]   rx_sr;
  logic [DataSz-1:0]   tx_sr;
  logic                we_q;

  logic                sck_rise;
  logic                sck_fall;
  logic                csn_s;
  logic [DataSz-1:0]   rx_byte;

  assign sck_rise  = sck_q[1] & ~sck_q[2];
  assign sck_fall  = ~sck_q[1] & sck_q[2];
  assign csn_s     = csn_q[1];
  assign rx_byte   = {rx_sr, sdi_q[1]};
  assign spi_sdo_o = tx_sr[DataSz-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      sck_q    <= '0;
      csn_q    <= '0;
      sdi_q    <= '0;
      bit_cnt  <= '0;
      rx_sr    <= '0;
      tx_sr    <= '0;
      we_q     <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
    end else begin
      sck_q <= {sck_q[1:0], spi_sck_i};
      csn_q <= {csn_q[0], spi_csn_i};
      sdi_q <= {sdi_q[0], spi_sdi_i};

      case (state)
        IDLE: begin
          if (!csn_s) begin
            state   <= CMD;
            bit_cnt <= '0;
            tx_sr   <= '0;
          end
        end

        CMD: begin
          if (csn_s) begin
            state <= IDLE;
          end else if (sck_rise) begin
            rx_sr   <= rx_byte[DataSz-2:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              we_q     <= rx_byte[DataSz-1];
              wb_adr_o <= rx_byte[AddrSz-1:0];
              if (rx_byte[DataSz-1]) begin
                state <= DATA;
              end else begin
                wb_we_o  <= 1'b0;
                wb_stb_o <= 1'b1;
                state    <= WB;
              end
            end
          end
        end

        DATA: begin
          if (csn_s) begin
            // Partial byte is dropped; no bus cycle for it.
            state <= IDLE;
            tx_sr <= '0;
          end else begin
            // bit_cnt==0 marks the trailing fall of the previous byte, which must not shift.
            if (sck_fall && bit_cnt != 3'd0) begin
              tx_sr <= {tx_sr[DataSz-2:0], 1'b0};
            end
            if (sck_rise) begin
              rx_sr   <= rx_byte[DataSz-2:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (we_q) begin
                  wb_dat_o <= rx_byte;
                  wb_we_o  <= 1'b1;
                end else begin
                  wb_adr_o <= wb_adr_o + AddrSz'(1);
                  wb_we_o  <= 1'b0;
                end
                wb_stb_o <= 1'b1;
                state    <= WB;
              end
            end
          end
        end

        WB: begin
          // Strobe is never dropped before ack, even if CSN has already gone high.
          if (wb_ack_i) begin
            wb_stb_o <= 1'b0;
            if (wb_we_o) begin
              wb_adr_o <= wb_adr_o + AddrSz'(1);
            end
            if (csn_s) begin
              state <= IDLE;
              tx_sr <= '0;
            end else begin
              state <= DATA;
              if (!wb_we_o) begin
                tx_sr <= wb_dat_i;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_wishbone_bridge.sv
// tb/tb_spi_wishbone_bridge.sv - scoreboard bench for spi_wishbone_bridge
module tb_spi_wishbone_bridge;

  localparam int HALF = 4;
  localparam int GAP  = 12;

  typedef struct packed {
    logic       we;
    logic [3:0] adr;
    logic [7:0] dat;
  } bus_t;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       csn = 1'b1;
  logic       sdi = 1'b0;
  logic       sdo;
  logic       wb_we;
  logic       wb_stb;
  logic       wb_ack;
  logic [3:0] wb_adr;
  logic [7:0] wb_dat;
  logic [7:0] wb_rdat;

  logic [7:0] bank[16];
  logic [7:0] model_mem[16];
  int         ack_delay = 0;
  int         wait_cnt;

  bus_t       exp_q[$];
  logic [7:0] exp_miso[$];
  bus_t       e;

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_strobes = 0;
  int         stb_len = 0;
  bit         unstable = 1'b0;
  bit         csn_seen = 1'b0;
  logic [3:0] held_adr;
  logic [7:0] held_dat;
  logic       held_we;

  spi_wishbone_bridge #(.AddrSz(4), .DataSz(8)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .spi_sck_i (sck),
    .spi_csn_i (csn),
    .spi_sdi_i (sdi),
    .spi_sdo_o (sdo),
    .wb_we_o   (wb_we),
    .wb_stb_o  (wb_stb),
    .wb_ack_i  (wb_ack),
    .wb_adr_o  (wb_adr),
    .wb_dat_o  (wb_dat),
    .wb_dat_i  (wb_rdat)
  );

  always #5 clk = ~clk;

  // Register-bank slave with programmable ack latency
  assign wb_ack  = wb_stb && (wait_cnt >= ack_delay);
  assign wb_rdat = bank[wb_adr];

  always @(posedge clk) begin
    if (rst || !wb_stb || wb_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    if (wb_stb && wb_ack && wb_we) bank[wb_adr] = wb_dat;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stb_len  = 0;
      unstable = 1'b0;
    end else if (wb_stb) begin
      if (spi_csn_high()) csn_seen = 1'b1;
      if (stb_len == 0) begin
        held_adr = wb_adr;
        held_dat = wb_dat;
        held_we  = wb_we;
      end else if (wb_adr !== held_adr || wb_dat !== held_dat || wb_we !== held_we) begin
        unstable = 1'b1;
      end
      stb_len++;
      if (wb_ack) begin
        n_strobes++;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'(wb_adr), 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("bus_we", 32'(wb_we), 32'(e.we));
          check("bus_adr", 32'(wb_adr), 32'(e.adr));
          if (e.we) check("bus_wdat", 32'(wb_dat), 32'(e.dat));
          check("stb_len", stb_len, ack_delay + 1);
          check("stb_stable", 32'(unstable), 0);
        end
        stb_len  = 0;
        unstable = 1'b0;
      end
    end
  end

  function automatic bit spi_csn_high();
    return csn;
  endfunction

  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      sdi = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = sdo;
      sck   = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic spi_frame(input byte_q_t b, input int tail);
    logic       we;
    logic [3:0] a;
    logic [7:0] rx;
    we = b[0][7];
    a  = b[0][3:0];
    for (int i = 1; i < b.size(); i++) begin
      if (we) begin
        exp_q.push_back({1'b1, a, b[i]});
        model_mem[a] = b[i];
      end else begin
        exp_q.push_back({1'b0, a, 8'h00});
        exp_miso.push_back(model_mem[a]);
      end
      a = a + 4'd1;
    end
    if (!we) exp_q.push_back({1'b0, a, 8'h00});

    csn = 1'b0;
    repeat (6) @(negedge clk);
    spi_xfer(b[0], 8, rx);
    check("miso_cmd", 32'(rx), 0);
    for (int i = 1; i < b.size(); i++) begin
      repeat (GAP) @(negedge clk);
      spi_xfer(b[i], 8, rx);
      if (!we) check("miso_data", 32'(rx), 32'(exp_miso.pop_front()));
    end
    repeat (tail) @(negedge clk);
    csn = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic wait_stb(input int limit);
    int k;
    k = 0;
    while (!wb_stb && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("stb_seen", 32'(wb_stb), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t    fb;
    logic [7:0] rx;
    int         s0;

    for (int i = 0; i < 16; i++) begin
      bank[i]      = 8'h00;
      model_mem[i] = 8'h00;
    end

    repeat (3) @(negedge clk);
    check("rst_stb", 32'(wb_stb), 0);
    check("rst_we", 32'(wb_we), 0);
    check("rst_adr", 32'(wb_adr), 0);
    check("rst_dat", 32'(wb_dat), 0);
    check("rst_sdo", 32'(sdo), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single write
    s0 = n_strobes;
    fb = {8'h82, 8'h5A};
    spi_frame(fb, 8);
    check("wr_strobes", n_strobes - s0, 1);
    check("reg2", 32'(bank[2]), 32'h5A);

    // Burst write with address wrap
    s0 = n_strobes;
    fb = {8'h8E, 8'h11, 8'h22, 8'h33};
    spi_frame(fb, 8);
    check("burst_strobes", n_strobes - s0, 3);
    check("regE", 32'(bank[14]), 32'h11);
    check("regF", 32'(bank[15]), 32'h22);
    check("reg0", 32'(bank[0]), 32'h33);

    // Read with prefetch
    bank[1]      = 8'hA5;
    model_mem[1] = 8'hA5;
    s0 = n_strobes;
    fb = {8'h01, 8'h00};
    spi_frame(fb, 8);
    check("rd_strobes", n_strobes - s0, 2);

    // Abort mid data byte
    s0 = n_strobes;
    csn = 1'b0;
    repeat (6) @(negedge clk);
    spi_xfer(8'h89, 8, rx);
    repeat (GAP) @(negedge clk);
    spi_xfer(8'hFF, 5, rx);
    repeat (4) @(negedge clk);
    csn = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_strobes", n_strobes - s0, 0);
    check("reg9_untouched", 32'(bank[9]), 0);
    s0 = n_strobes;
    fb = {8'h83, 8'h77};
    spi_frame(fb, 8);
    check("post_abort_strobes", n_strobes - s0, 1);
    check("reg3", 32'(bank[3]), 32'h77);

    // Slow ack: burst write then two-byte read
    ack_delay = 3;
    fb = {8'h8A, 8'hB1, 8'hB2};
    spi_frame(fb, 8);
    check("regA", 32'(bank[10]), 32'hB1);
    check("regB", 32'(bank[11]), 32'hB2);
    fb = {8'h0A, 8'h00, 8'h00};
    spi_frame(fb, 8);

    // CSN rises while the slave is still holding off ack
    ack_delay = 10;
    csn_seen  = 1'b0;
    s0 = n_strobes;
    fb = {8'h84, 8'h3C};
    spi_frame(fb, 4);
    check("csn_during_stb", 32'(csn_seen), 1);
    check("csn_wait_strobes", n_strobes - s0, 1);
    check("reg4", 32'(bank[4]), 32'h3C);

    // Asynchronous reset while a write strobe is pending
    csn = 1'b0;
    repeat (6) @(negedge clk);
    spi_xfer(8'h85, 8, rx);
    repeat (GAP) @(negedge clk);
    spi_xfer(8'hC3, 8, rx);
    wait_stb(40);
    check("pre_rst_we", 32'(wb_we), 1);
    check("pre_rst_adr", 32'(wb_adr), 5);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_stb", 32'(wb_stb), 0);
    check("arst_we", 32'(wb_we), 0);
    check("arst_adr", 32'(wb_adr), 0);
    check("arst_dat", 32'(wb_dat), 0);
    check("arst_sdo", 32'(sdo), 0);
    exp_q.delete();
    csn = 1'b1;
    sck = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    ack_delay = 0;
    repeat (5) @(negedge clk);
    check("reg5_abandoned", 32'(bank[5]), 0);
    s0 = n_strobes;
    fb = {8'h86, 8'h99};
    spi_frame(fb, 8);
    check("post_rst_strobes", n_strobes - s0, 1);
    check("reg6", 32'(bank[6]), 32'h99);

    check("exp_q_empty", exp_q.size(), 0);
    check("exp_miso_empty", exp_miso.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
